// File: rtl/chrisruk_glyph_loader.sv
// -----------------------------------------------------------------------------
// chrisruk_glyph_loader
//
// Feeds the 8x8 LED-matrix strip driver. ASCII characters arrive on a slow
// 3-wire serial link and are queued in a small FIFO. One glyph index
// (0..25 = 'a'..'z') is shown at a time. The shown glyph changes only on a
// driver frame boundary, and each glyph is held for HOLD_FRAMES frames.
//
// Parameters:
//   FIFO_DEPTH    character FIFO entries (power of 2, >= 2)
//   HOLD_FRAMES   frames each glyph is held before the next pop (>= 1)
//
// Ports:
//   i_clk          system clock; all logic runs on its rising edge
//   i_rst_n        asynchronous active-low reset
//   i_ser_clk      serial bit clock, asynchronous to i_clk (rising-edge data)
//   i_ser_dat      serial data, MSB first
//   i_ser_cs_n     active-low byte framing; high discards a partial byte
//   i_frame_done   one-cycle pulse from the driver at the end of each frame
//   o_glyph_idx    current glyph index, 0..25
//   o_glyph_valid  high once a glyph has been loaded
//   o_fifo_full    FIFO holds FIFO_DEPTH entries
//   o_fifo_empty   FIFO holds no entries
//   o_rx_error     sticky: a completed byte was outside 'a'..'z'
//   o_rx_overflow  sticky: a valid byte was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module chrisruk_glyph_loader #(
   parameter int FIFO_DEPTH  = 8,
   parameter int HOLD_FRAMES = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_ser_clk,
   input  logic       i_ser_dat,
   input  logic       i_ser_cs_n,
   input  logic       i_frame_done,
   output logic [4:0] o_glyph_idx,
   output logic       o_glyph_valid,
   output logic       o_fifo_full,
   output logic       o_fifo_empty,
   output logic       o_rx_error,
   output logic       o_rx_overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int HW = $clog2(HOLD_FRAMES) + 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic {IDLE, SHOW} state_t;

   // Synchronizers and serial receiver
   logic          r_sclk_s1, r_sclk_s2, r_sclk_d;
   logic          r_dat_s1, r_dat_s2;
   logic          r_cs_s1, r_cs_s2;
   logic [6:0]    r_sr;
   logic [2:0]    r_bitcnt;
   logic          w_sclk_rise;
   logic          w_byte_done;
   logic [7:0]    w_byte;
   logic          w_byte_ok;
   logic          w_wr_req;
   logic          w_byte_bad;
   logic [4:0]    w_wdata;

   // FIFO
   logic [4:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_next;
   logic          r_fifo_full, r_fifo_empty;
   logic          w_wr_acc;
   logic [4:0]    w_head;

   // Display FSM
   state_t        r_state, w_state_next;
   logic [HW-1:0] r_hold;
   logic [4:0]    r_glyph_idx;
   logic          r_glyph_valid;
   logic          w_pop;
   logic          w_hold_inc;

   // Sticky flags
   logic          r_rx_error, r_rx_overflow;

   // Two-flop synchronizers on all serial pins; a third flop on the bit clock
   // gives the previous synced value for rising-edge detection. The framing
   // chain resets high so the receiver starts out deselected.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sclk_s1 <= 1'b0;
         r_sclk_s2 <= 1'b0;
         r_sclk_d  <= 1'b0;
         r_dat_s1  <= 1'b0;
         r_dat_s2  <= 1'b0;
         r_cs_s1   <= 1'b1;
         r_cs_s2   <= 1'b1;
      end else begin
         r_sclk_s1 <= i_ser_clk;
         r_sclk_s2 <= r_sclk_s1;
         r_sclk_d  <= r_sclk_s2;
         r_dat_s1  <= i_ser_dat;
         r_dat_s2  <= r_dat_s1;
         r_cs_s1   <= i_ser_cs_n;
         r_cs_s2   <= r_cs_s1;
      end
   end

   assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;

   // The shift register keeps only the 7 most recent bits. The 8th bit is
   // taken straight from the synchronizer in the cycle the byte completes.
   assign w_byte      = {r_sr, r_dat_s2};
   assign w_byte_done = w_sclk_rise & ~r_cs_s2 & (r_bitcnt == 3'd7);
   assign w_byte_ok   = (w_byte >= 8'h61) && (w_byte <= 8'h7A);
   assign w_wr_req    = w_byte_done & w_byte_ok;
   assign w_byte_bad  = w_byte_done & ~w_byte_ok;
   // 'a'..'z' have low five bits 1..26, so subtracting one gives 0..25.
   assign w_wdata     = w_byte[4:0] - 5'd1;

   // Bit counter is held at zero while deselected, so a raised framing line
   // throws away any partial byte. It wraps to zero on the 8th bit.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sr     <= '0;
         r_bitcnt <= '0;
      end else if (r_cs_s2) begin
         r_bitcnt <= '0;
      end else if (w_sclk_rise) begin
         r_sr     <= {r_sr[5:0], r_dat_s2};
         r_bitcnt <= r_bitcnt + 3'd1;
      end
   end

   // A pop in the same cycle frees a slot, so a write into a full FIFO is
   // still accepted then. When full, the write slot equals the read slot, and
   // the popped value is read before the write lands.
   assign w_wr_acc = w_wr_req & ((r_count != COUNT_FULL) | w_pop);
   assign w_head   = r_mem[r_rptr];

   always_ff @(posedge i_clk) begin
      if (w_wr_acc) begin
         r_mem[r_wptr] <= w_wdata;
      end
   end

   always_comb begin
      w_count_next = r_count;
      if (w_wr_acc && !w_pop) begin
         w_count_next = r_count + CW'(1);
      end else if (!w_wr_acc && w_pop) begin
         w_count_next = r_count - CW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_fifo_full  <= 1'b0;
         r_fifo_empty <= 1'b1;
      end else begin
         if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
         if (w_pop)    r_rptr <= r_rptr + AW'(1);
         r_count      <= w_count_next;
         r_fifo_full  <= (w_count_next == COUNT_FULL);
         r_fifo_empty <= (w_count_next == '0);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rx_error    <= 1'b0;
         r_rx_overflow <= 1'b0;
      end else begin
         r_rx_error    <= r_rx_error | w_byte_bad;
         r_rx_overflow <= r_rx_overflow | (w_wr_req & ~w_wr_acc);
      end
   end

   // Display FSM next state. All decisions are made only on a frame_done
   // cycle. Once a glyph is shown, SHOW is never left. With an empty FIFO the
   // hold counter saturates, so the last glyph stays on the display.
   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      w_hold_inc   = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_frame_done && !r_fifo_empty) begin
               w_pop        = 1'b1;
               w_state_next = SHOW;
            end
         end
         SHOW: begin
            if (i_frame_done) begin
               if (r_hold == HOLD_LAST && !r_fifo_empty) begin
                  w_pop = 1'b1;
               end else if (r_hold < HOLD_LAST) begin
                  w_hold_inc = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // A popped glyph appears on the outputs one edge after the frame_done cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_glyph_idx   <= '0;
         r_glyph_valid <= 1'b0;
         r_hold        <= '0;
      end else if (w_pop) begin
         r_glyph_idx   <= w_head;
         r_glyph_valid <= 1'b1;
         r_hold        <= '0;
      end else if (w_hold_inc) begin
         r_hold        <= r_hold + HW'(1);
      end
   end

   assign o_glyph_idx   = r_glyph_idx;
   assign o_glyph_valid = r_glyph_valid;
   assign o_fifo_full   = r_fifo_full;
   assign o_fifo_empty  = r_fifo_empty;
   assign o_rx_error    = r_rx_error;
   assign o_rx_overflow = r_rx_overflow;

endmodule

// File: tb/tb_chrisruk_glyph_loader.sv
// -----------------------------------------------------------------------------
// tb_chrisruk_glyph_loader
//
// Directed testbench for chrisruk_glyph_loader (FIFO_DEPTH=8, HOLD_FRAMES=4).
// It bit-bangs serial bytes with an 8-clock ser_clk period and pulses
// frame_done. Each observed value is compared against a hand-computed
// expectation.
// -----------------------------------------------------------------------------
module tb_chrisruk_glyph_loader;

   logic       clk = 1'b0;
   logic       rstN;
   logic       serClk;
   logic       serDat;
   logic       serCsN;
   logic       frameDone;
   logic [4:0] glyphIdx;
   logic       glyphValid;
   logic       fifoFull;
   logic       fifoEmpty;
   logic       rxError;
   logic       rxOverflow;

   int nChecks = 0;
   int nErrors = 0;

   chrisruk_glyph_loader #(
      .FIFO_DEPTH (8),
      .HOLD_FRAMES(4)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rstN),
      .i_ser_clk    (serClk),
      .i_ser_dat    (serDat),
      .i_ser_cs_n   (serCsN),
      .i_frame_done (frameDone),
      .o_glyph_idx  (glyphIdx),
      .o_glyph_valid(glyphValid),
      .o_fifo_full  (fifoFull),
      .o_fifo_empty (fifoEmpty),
      .o_rx_error   (rxError),
      .o_rx_overflow(rxOverflow)
   );

   // 10-unit system clock; stimulus is driven and sampled on the falling edge
   always #5 clk = ~clk;

   // Safety net so a broken design can never hang the run
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single place where every comparison is counted and reported
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle frame_done pulse, returning on the negedge after it was sampled
   task automatic pulseFrame();
      frameDone = 1'b1;
      waitClk(1);
      frameDone = 1'b0;
   endtask

   task automatic doReset();
      rstN      = 1'b0;
      serCsN    = 1'b1;
      serClk    = 1'b0;
      serDat    = 1'b0;
      frameDone = 1'b0;
      waitClk(3);
      rstN = 1'b1;
      waitClk(2);
   endtask

   // Sends the top nbits of b, MSB first, with a 4-low/4-high ser_clk.
   // mode 1: check fifo_empty timing around the 8th edge
   // mode 2: pulse frame_done in the very cycle the 8th bit completes
   // mode 3: assert reset asynchronously after the bits, mid-byte
   task automatic applyStimulus(input logic [7:0] b, input int nbits, input int mode);
      serCsN = 1'b0;
      waitClk(4);
      for (int i = 0; i < nbits; i++) begin
         serDat = b[7-i];
         waitClk(4);
         serClk = 1'b1;
         if (i == 7 && mode == 1) begin
            @(posedge clk);
            @(posedge clk);
            #1 checkOutput("empty_before_write", fifoEmpty, 1);
            @(posedge clk);
            #1 checkOutput("empty_after_write", fifoEmpty, 0);
            @(negedge clk);
         end else if (i == 7 && mode == 2) begin
            waitClk(2);
            frameDone = 1'b1;
            waitClk(1);
            frameDone = 1'b0;
            checkOutput("simul_full", fifoFull, 1);
            checkOutput("simul_overflow", rxOverflow, 0);
            checkOutput("simul_idx", glyphIdx, 0);
            checkOutput("simul_valid", glyphValid, 1);
            waitClk(1);
         end else begin
            waitClk(4);
         end
         serClk = 1'b0;
      end
      if (mode == 3) begin
         #2 rstN = 1'b0;
         #1;
         checkOutput("async_idx", glyphIdx, 0);
         checkOutput("async_valid", glyphValid, 0);
         checkOutput("async_full", fifoFull, 0);
         checkOutput("async_empty", fifoEmpty, 1);
         checkOutput("async_error", rxError, 0);
         checkOutput("async_overflow", rxOverflow, 0);
         @(negedge clk);
         rstN = 1'b1;
      end
      waitClk(4);
      serCsN = 1'b1;
      waitClk(4);
   endtask

   // Main directed sequence
   initial begin
      int expIdx;

      rstN      = 1'b0;
      serCsN    = 1'b1;
      serClk    = 1'b0;
      serDat    = 1'b0;
      frameDone = 1'b0;
      waitClk(2);

      // Reset values while held, then frame pulses with no traffic
      checkOutput("rst_idx", glyphIdx, 0);
      checkOutput("rst_valid", glyphValid, 0);
      checkOutput("rst_full", fifoFull, 0);
      checkOutput("rst_empty", fifoEmpty, 1);
      checkOutput("rst_error", rxError, 0);
      checkOutput("rst_overflow", rxOverflow, 0);
      rstN = 1'b1;
      waitClk(2);
      for (int f = 0; f < 3; f++) begin
         pulseFrame();
         waitClk(1);
      end
      checkOutput("idle_valid", glyphValid, 0);
      checkOutput("idle_idx", glyphIdx, 0);
      checkOutput("idle_empty", fifoEmpty, 1);

      // Single character 'c'
      applyStimulus(8'h63, 8, 1);
      checkOutput("c_valid_before_frame", glyphValid, 0);
      pulseFrame();
      checkOutput("c_idx", glyphIdx, 2);
      checkOutput("c_valid", glyphValid, 1);
      checkOutput("c_empty", fifoEmpty, 1);

      // "abz" with a four-frame hold, then persistence of the last glyph
      doReset();
      applyStimulus(8'h61, 8, 0);
      applyStimulus(8'h62, 8, 0);
      applyStimulus(8'h7A, 8, 0);
      for (int f = 1; f <= 19; f++) begin
         pulseFrame();
         expIdx = (f <= 4) ? 0 : ((f <= 8) ? 1 : 25);
         checkOutput($sformatf("seq_idx_f%0d", f), glyphIdx, expIdx);
         if (f == 8) checkOutput("seq_empty_f8", fifoEmpty, 0);
         if (f == 9) checkOutput("seq_empty_f9", fifoEmpty, 1);
         waitClk(1);
      end

      // Invalid byte, then a partial byte followed by 'b'
      doReset();
      applyStimulus(8'h41, 8, 0);
      checkOutput("bad_error", rxError, 1);
      checkOutput("bad_empty", fifoEmpty, 1);
      applyStimulus(8'hA5, 5, 0);
      applyStimulus(8'h62, 8, 0);
      checkOutput("partial_empty", fifoEmpty, 0);
      checkOutput("partial_full", fifoFull, 0);
      checkOutput("error_sticky", rxError, 1);
      pulseFrame();
      checkOutput("partial_idx", glyphIdx, 1);
      checkOutput("partial_one_entry", fifoEmpty, 1);

      // Overflow: nine bytes into an eight-entry FIFO
      doReset();
      for (int k = 0; k < 9; k++) begin
         applyStimulus(8'(8'h61 + k), 8, 0);
         if (k == 6) checkOutput("ovf_full_at7", fifoFull, 0);
         if (k == 7) begin
            checkOutput("ovf_full_at8", fifoFull, 1);
            checkOutput("ovf_flag_at8", rxOverflow, 0);
         end
      end
      checkOutput("ovf_flag", rxOverflow, 1);
      checkOutput("ovf_full", fifoFull, 1);
      checkOutput("ovf_no_error", rxError, 0);
      for (int f = 1; f <= 32; f++) begin
         pulseFrame();
         if (f % 4 == 1) checkOutput($sformatf("ovf_pop_f%0d", f), glyphIdx, (f - 1) / 4);
         waitClk(1);
      end
      checkOutput("ovf_drained", fifoEmpty, 1);

      // Full FIFO: a byte completing in the same cycle as a pop is kept
      doReset();
      for (int k = 0; k < 8; k++) applyStimulus(8'(8'h61 + k), 8, 0);
      applyStimulus(8'h78, 8, 2);
      for (int f = 2; f <= 33; f++) begin
         pulseFrame();
         if (f % 4 == 1) begin
            expIdx = ((f - 1) / 4 < 8) ? (f - 1) / 4 : 23;
            checkOutput($sformatf("simul_pop_f%0d", f), glyphIdx, expIdx);
         end
         waitClk(1);
      end
      checkOutput("simul_no_overflow", rxOverflow, 0);

      // Async reset in the middle of a byte, then clean reception of 'd'
      applyStimulus(8'h41, 8, 0);
      checkOutput("pre_reset_error", rxError, 1);
      applyStimulus(8'h64, 4, 3);
      applyStimulus(8'h64, 8, 0);
      pulseFrame();
      checkOutput("post_reset_idx", glyphIdx, 3);
      checkOutput("post_reset_valid", glyphValid, 1);
      checkOutput("post_reset_empty", fifoEmpty, 1);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
